// File: rtl/trng_pkg.sv
// Shared types and default sizing for the TRNG sequencing controller.
package trng_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WARMUP    = 3'd1,
    ST_COLLECT   = 3'd2,
    ST_HASH_REQ  = 3'd3,
    ST_HASH_WAIT = 3'd4,
    ST_FAIL      = 3'd5
  } trng_state_e;

  localparam int unsigned DEF_WARMUP_CYCLES = 1024;
  localparam int unsigned DEF_RCT_CUTOFF    = 21;
  localparam int unsigned DEF_BLOCK_BITS    = 448;
  localparam int unsigned DEF_FAIL_HOLD     = 16;
  localparam int unsigned FAIL_CNT_W        = 8;

endpackage

// File: rtl/trng_rct.sv
// Repetition Count Test: tracks the current run of identical raw bits and
// flags the valid bit that makes the run reach the cutoff.
module trng_rct
  import trng_pkg::*;
#(
  parameter int unsigned RCT_CUTOFF = DEF_RCT_CUTOFF,
  parameter int unsigned LEN_W      = $clog2(RCT_CUTOFF + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             bit_in,
  input  logic             valid,
  input  logic             enable,
  output logic             fail_now,
  output logic [LEN_W-1:0] run_len
);

  localparam logic [LEN_W-1:0] CUT_V = LEN_W'(RCT_CUTOFF);

  logic             r_last_bit;
  logic [LEN_W-1:0] r_run_len;
  logic [LEN_W-1:0] w_len_nxt;
  logic             w_upd;

  assign w_upd = valid & enable;

  // run_len of zero marks "cleared", so the first bit always starts a run of one
  always_comb begin
    w_len_nxt = LEN_W'(1);
    if ((r_run_len != '0) && (bit_in == r_last_bit)) begin
      w_len_nxt = (r_run_len == CUT_V) ? r_run_len : r_run_len + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_bit <= 1'b0;
      r_run_len  <= '0;
    end else if (clr) begin
      r_last_bit <= 1'b0;
      r_run_len  <= '0;
    end else if (w_upd) begin
      r_last_bit <= bit_in;
      r_run_len  <= w_len_nxt;
    end
  end

  assign fail_now = w_upd & (w_len_nxt == CUT_V);
  assign run_len  = r_run_len;

endmodule

// File: rtl/trng_seq_ctrl.sv
// TRNG sequencing controller: warm-up, health test, block fill / raw forward.
//   state     | meaning
//   IDLE      | stopped, run low
//   WARMUP    | discarding source output for WARMUP_CYCLES
//   COLLECT   | health-testing and writing/forwarding bits
//   HASH_REQ  | block full, issuing hash_start
//   HASH_WAIT | waiting for hash_done
//   FAIL      | health failure, held FAIL_HOLD cycles
module trng_seq_ctrl
  import trng_pkg::*;
#(
  parameter int unsigned WARMUP_CYCLES = DEF_WARMUP_CYCLES,
  parameter int unsigned RCT_CUTOFF    = DEF_RCT_CUTOFF,
  parameter int unsigned BLOCK_BITS    = DEF_BLOCK_BITS,
  parameter int unsigned FAIL_HOLD     = DEF_FAIL_HOLD
) (
  input  logic                  TRNG_Clock,
  input  logic                  TRNG_Reset,
  input  logic                  run,
  input  logic                  ctrl_mode,
  input  logic                  raw_bit,
  input  logic                  raw_valid,
  output logic                  buf_wr_en,
  output logic                  buf_wr_data,
  output logic                  buf_clr,
  output logic                  hash_start,
  input  logic                  hash_done,
  output logic                  hash_rdy,
  output logic                  raw_out,
  output logic                  raw_out_valid,
  output logic                  failure,
  output logic [FAIL_CNT_W-1:0] fail_count,
  output logic [2:0]            state_o
);

  localparam int unsigned WU_W   = $clog2(WARMUP_CYCLES);
  localparam int unsigned BC_W   = $clog2(BLOCK_BITS + 1);
  localparam int unsigned HOLD_W = $clog2(FAIL_HOLD + 1);
  localparam int unsigned LEN_W  = $clog2(RCT_CUTOFF + 1);

  localparam logic [WU_W-1:0]   WU_LAST   = WU_W'(WARMUP_CYCLES - 1);
  localparam logic [BC_W-1:0]   BLK_LAST  = BC_W'(BLOCK_BITS - 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(FAIL_HOLD - 1);

  trng_state_e r_state, w_state_nxt;
  logic [WU_W-1:0]       r_wu_cnt, w_wu_nxt;
  logic [HOLD_W-1:0]     r_hold_cnt, w_hold_nxt;
  logic [BC_W-1:0]       r_bit_cnt, w_bit_nxt;
  logic                  r_mode_q, w_mode_nxt;
  logic [FAIL_CNT_W-1:0] r_fail_cnt, w_fail_cnt_nxt;
  logic r_wr_en, r_wr_data, r_buf_clr, r_hash_start, r_hash_rdy;
  logic r_raw_out, r_raw_out_valid, r_failure;
  logic w_wr_en, w_wr_data, w_buf_clr, w_hash_start, w_hash_rdy;
  logic w_raw_out, w_raw_out_valid, w_failure;
  logic w_rct_en, w_rct_clr, w_fail_now;
  logic [LEN_W-1:0] w_unused_run_len;

  assign w_rct_en  = run & (r_state == ST_COLLECT);
  assign w_rct_clr = run & (r_state == ST_WARMUP) & (r_wu_cnt == WU_LAST);

  trng_rct #(.RCT_CUTOFF(RCT_CUTOFF)) u_rct (
    .clk      (TRNG_Clock),
    .rst      (TRNG_Reset),
    .clr      (w_rct_clr),
    .bit_in   (raw_bit),
    .valid    (raw_valid),
    .enable   (w_rct_en),
    .fail_now (w_fail_now),
    .run_len  (w_unused_run_len)
  );

  always_comb begin
    w_state_nxt     = r_state;
    w_wu_nxt        = r_wu_cnt;
    w_hold_nxt      = r_hold_cnt;
    w_bit_nxt       = r_bit_cnt;
    w_mode_nxt      = r_mode_q;
    w_fail_cnt_nxt  = r_fail_cnt;
    w_wr_en         = 1'b0;
    w_wr_data       = 1'b0;
    w_buf_clr       = 1'b0;
    w_hash_start    = 1'b0;
    w_hash_rdy      = 1'b0;
    w_raw_out       = 1'b0;
    w_raw_out_valid = 1'b0;
    if (!run) begin
      w_state_nxt = ST_IDLE;
      w_buf_clr   = (r_state != ST_IDLE);
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt = ST_WARMUP;
          w_wu_nxt    = '0;
        end
        ST_WARMUP: begin
          if (r_wu_cnt == WU_LAST) begin
            w_state_nxt = ST_COLLECT;
            w_mode_nxt  = ctrl_mode;
            w_bit_nxt   = '0;
          end else begin
            w_wu_nxt = r_wu_cnt + 1'b1;
          end
        end
        ST_COLLECT: begin
          if (raw_valid) begin
            // a failing bit is dropped outright, even if it would complete the block
            if (w_fail_now) begin
              w_state_nxt = ST_FAIL;
              w_buf_clr   = 1'b1;
              w_hold_nxt  = HOLD_LOAD;
              if (r_fail_cnt != '1) w_fail_cnt_nxt = r_fail_cnt + 1'b1;
            end else if (!r_mode_q) begin
              w_wr_en   = 1'b1;
              w_wr_data = raw_bit;
              w_bit_nxt = r_bit_cnt + 1'b1;
              if (r_bit_cnt == BLK_LAST) w_state_nxt = ST_HASH_REQ;
            end else begin
              w_raw_out_valid = 1'b1;
              w_raw_out       = raw_bit;
            end
          end
        end
        ST_HASH_REQ: begin
          w_hash_start = 1'b1;
          w_state_nxt  = ST_HASH_WAIT;
        end
        ST_HASH_WAIT: begin
          if (hash_done) begin
            w_state_nxt = ST_COLLECT;
            w_hash_rdy  = 1'b1;
            w_buf_clr   = 1'b1;
            w_bit_nxt   = '0;
            w_mode_nxt  = ctrl_mode;
          end
        end
        ST_FAIL: begin
          if (r_hold_cnt == '0) begin
            w_state_nxt = ST_WARMUP;
            w_wu_nxt    = '0;
          end else begin
            w_hold_nxt = r_hold_cnt - 1'b1;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
    w_failure = (w_state_nxt == ST_FAIL);
  end

  always_ff @(posedge TRNG_Clock or posedge TRNG_Reset) begin
    if (TRNG_Reset) begin
      r_state         <= ST_IDLE;
      r_wu_cnt        <= '0;
      r_hold_cnt      <= '0;
      r_bit_cnt       <= '0;
      r_mode_q        <= 1'b0;
      r_fail_cnt      <= '0;
      r_wr_en         <= 1'b0;
      r_wr_data       <= 1'b0;
      r_buf_clr       <= 1'b0;
      r_hash_start    <= 1'b0;
      r_hash_rdy      <= 1'b0;
      r_raw_out       <= 1'b0;
      r_raw_out_valid <= 1'b0;
      r_failure       <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_wu_cnt        <= w_wu_nxt;
      r_hold_cnt      <= w_hold_nxt;
      r_bit_cnt       <= w_bit_nxt;
      r_mode_q        <= w_mode_nxt;
      r_fail_cnt      <= w_fail_cnt_nxt;
      r_wr_en         <= w_wr_en;
      r_wr_data       <= w_wr_data;
      r_buf_clr       <= w_buf_clr;
      r_hash_start    <= w_hash_start;
      r_hash_rdy      <= w_hash_rdy;
      r_raw_out       <= w_raw_out;
      r_raw_out_valid <= w_raw_out_valid;
      r_failure       <= w_failure;
    end
  end

  assign buf_wr_en     = r_wr_en;
  assign buf_wr_data   = r_wr_data;
  assign buf_clr       = r_buf_clr;
  assign hash_start    = r_hash_start;
  assign hash_rdy      = r_hash_rdy;
  assign raw_out       = r_raw_out;
  assign raw_out_valid = r_raw_out_valid;
  assign failure       = r_failure;
  assign fail_count    = r_fail_cnt;
  assign state_o       = r_state;

endmodule

// File: tb/tb_trng_seq_ctrl.sv
// Directed bench for trng_seq_ctrl with small parameters (8/5/16/4).
module tb_trng_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst, run, ctrl_mode, raw_bit, raw_valid, hash_done;
  logic       buf_wr_en, buf_wr_data, buf_clr, hash_start, hash_rdy;
  logic       raw_out, raw_out_valid, failure;
  logic [7:0] fail_count;
  logic [2:0] state_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic tb_bit;

  trng_seq_ctrl #(
    .WARMUP_CYCLES(8), .RCT_CUTOFF(5), .BLOCK_BITS(16), .FAIL_HOLD(4)
  ) dut (
    .TRNG_Clock   (clk),
    .TRNG_Reset   (rst),
    .run          (run),
    .ctrl_mode    (ctrl_mode),
    .raw_bit      (raw_bit),
    .raw_valid    (raw_valid),
    .buf_wr_en    (buf_wr_en),
    .buf_wr_data  (buf_wr_data),
    .buf_clr      (buf_clr),
    .hash_start   (hash_start),
    .hash_done    (hash_done),
    .hash_rdy     (hash_rdy),
    .raw_out      (raw_out),
    .raw_out_valid(raw_out_valid),
    .failure      (failure),
    .fail_count   (fail_count),
    .state_o      (state_o)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic do_reset;
    rst = 1'b1; run = 1'b0; ctrl_mode = 1'b0; raw_bit = 1'b0;
    raw_valid = 1'b0; hash_done = 1'b0;
    tick; tick;
    rst = 1'b0;
    tick;
  endtask

  task automatic start_collect(input logic mode);
    int k;
    run = 1'b1; ctrl_mode = mode; raw_valid = 1'b0;
    k = 0;
    while (state_o != 3'd2 && k < 30) begin
      tick;
      k++;
    end
    check_eq("reach_collect", {29'd0, state_o}, 32'd2);
  endtask

  task automatic send_block(input int n);
    for (int i = 0; i < n; i++) begin
      raw_valid = 1'b1; raw_bit = tb_bit; tb_bit = ~tb_bit;
      tick;
    end
  endtask

  initial begin
    int n_wr, n_hs, n_rov, n_hr, n_clr, n_ev, t;
    logic exp_bit, prev_fail;
    logic [5:0] rct_bits;
    logic [3:0] raw_bits;

    // reset values while reset is held
    rst = 1'b1; run = 1'b0; ctrl_mode = 1'b0; raw_bit = 1'b0;
    raw_valid = 1'b0; hash_done = 1'b0; tb_bit = 1'b0;
    tick; tick;
    check_eq("rst_state", {29'd0, state_o}, 32'd0);
    check_eq("rst_outs", {24'd0, buf_wr_en, buf_clr, hash_start, hash_rdy,
                          raw_out_valid, failure, raw_out, buf_wr_data}, 32'd0);
    check_eq("rst_fail_count", {24'd0, fail_count}, 32'd0);
    rst = 1'b0;
    tick;

    // warm-up with valid bits arriving from cycle 0
    run = 1'b1; ctrl_mode = 1'b0; raw_valid = 1'b1;
    n_wr = 0;
    for (int i = 0; i < 8; i++) begin
      raw_bit = tb_bit; tb_bit = ~tb_bit;
      tick;
      check_eq("wu_state", {29'd0, state_o}, 32'd1);
      n_wr += int'(buf_wr_en);
    end
    check_eq("wu_no_write", n_wr, 0);
    raw_bit = tb_bit; tb_bit = ~tb_bit;
    tick;
    check_eq("collect_entry_state", {29'd0, state_o}, 32'd2);
    check_eq("collect_entry_no_wr", {31'd0, buf_wr_en}, 32'd0);

    // full hashed block
    for (int i = 0; i < 16; i++) begin
      exp_bit = tb_bit;
      raw_bit = tb_bit; tb_bit = ~tb_bit;
      tick;
      check_eq("blk_wr_en", {31'd0, buf_wr_en}, 32'd1);
      check_eq("blk_wr_data", {31'd0, buf_wr_data}, {31'd0, exp_bit});
    end
    check_eq("blk_hash_req", {29'd0, state_o}, 32'd3);
    raw_bit = tb_bit; tb_bit = ~tb_bit;
    tick;
    check_eq("hash_start", {31'd0, hash_start}, 32'd1);
    check_eq("hash_start_no_wr", {31'd0, buf_wr_en}, 32'd0);
    check_eq("hash_wait_state", {29'd0, state_o}, 32'd4);
    n_wr = 0; n_hs = 0;
    for (int i = 0; i < 10; i++) begin
      raw_bit = tb_bit; tb_bit = ~tb_bit;
      tick;
      n_wr += int'(buf_wr_en);
      n_hs += int'(hash_start);
    end
    check_eq("hash_wait_no_wr", n_wr, 0);
    check_eq("hash_start_once", n_hs, 0);
    check_eq("hash_wait_hold", {29'd0, state_o}, 32'd4);
    hash_done = 1'b1;
    tick;
    hash_done = 1'b0;
    check_eq("hash_rdy", {31'd0, hash_rdy}, 32'd1);
    check_eq("hash_buf_clr", {31'd0, buf_clr}, 32'd1);
    check_eq("hash_back_collect", {29'd0, state_o}, 32'd2);
    raw_bit = tb_bit; tb_bit = ~tb_bit;
    tick;
    check_eq("hash_rdy_pulse", {30'd0, hash_rdy, buf_clr}, 32'd0);
    check_eq("resume_wr", {31'd0, buf_wr_en}, 32'd1);

    // RCT failure: 1,0,0,0,0 written, fifth zero fails
    do_reset;
    start_collect(1'b0);
    rct_bits = 6'b000001;
    for (int j = 0; j < 5; j++) begin
      raw_valid = 1'b1; raw_bit = rct_bits[j];
      tick;
      check_eq("rct_wr_en", {31'd0, buf_wr_en}, 32'd1);
      check_eq("rct_wr_data", {31'd0, buf_wr_data}, {31'd0, rct_bits[j]});
    end
    raw_bit = rct_bits[5];
    tick;
    raw_valid = 1'b0;
    check_eq("rct_drop", {31'd0, buf_wr_en}, 32'd0);
    check_eq("rct_fail_state", {29'd0, state_o}, 32'd5);
    check_eq("rct_failure", {31'd0, failure}, 32'd1);
    check_eq("rct_buf_clr", {31'd0, buf_clr}, 32'd1);
    check_eq("rct_fail_count", {24'd0, fail_count}, 32'd1);
    n_clr = 0;
    for (int k = 0; k < 3; k++) begin
      tick;
      check_eq("fail_hold", {31'd0, failure}, 32'd1);
      n_clr += int'(buf_clr);
    end
    check_eq("fail_clr_once", n_clr, 0);
    tick;
    check_eq("fail_rewarm", {29'd0, state_o}, 32'd1);
    check_eq("fail_cleared", {31'd0, failure}, 32'd0);
    for (int k = 0; k < 7; k++) tick;
    check_eq("rewarm_len", {29'd0, state_o}, 32'd1);
    tick;
    check_eq("rewarm_done", {29'd0, state_o}, 32'd2);

    // raw mode, with a mid-stream ctrl_mode change
    do_reset;
    start_collect(1'b1);
    raw_bits = 4'b1101;
    for (int j = 0; j < 4; j++) begin
      raw_valid = 1'b1; raw_bit = raw_bits[j];
      if (j == 2) ctrl_mode = 1'b0;
      tick;
      check_eq("raw_valid", {31'd0, raw_out_valid}, 32'd1);
      check_eq("raw_data", {31'd0, raw_out}, {31'd0, raw_bits[j]});
      check_eq("raw_no_wr", {31'd0, buf_wr_en}, 32'd0);
    end
    n_wr = 0; n_hs = 0; n_rov = 0; tb_bit = 1'b0;
    for (int j = 0; j < 20; j++) begin
      raw_bit = tb_bit; tb_bit = ~tb_bit;
      tick;
      n_wr += int'(buf_wr_en);
      n_hs += int'(hash_start);
      n_rov += int'(raw_out_valid);
    end
    check_eq("raw_stream_fwd", n_rov, 20);
    check_eq("raw_stream_no_wr", n_wr, 0);
    check_eq("raw_stream_no_hash", n_hs, 0);
    raw_valid = 1'b0;
    tick;
    check_eq("raw_idle_valid", {31'd0, raw_out_valid}, 32'd0);

    // abort during HASH_WAIT, late hash_done ignored
    do_reset;
    start_collect(1'b0);
    send_block(16);
    raw_valid = 1'b0;
    tick;
    check_eq("abort_in_wait", {29'd0, state_o}, 32'd4);
    run = 1'b0;
    tick;
    check_eq("abort_idle", {29'd0, state_o}, 32'd0);
    check_eq("abort_buf_clr", {31'd0, buf_clr}, 32'd1);
    tick; tick;
    run = 1'b1;
    tick;
    check_eq("abort_rewarm", {29'd0, state_o}, 32'd1);
    hash_done = 1'b1;
    tick;
    hash_done = 1'b0;
    check_eq("abort_done_ignored", {29'd0, state_o}, 32'd1);
    n_hr = int'(hash_rdy);
    t = 0;
    while (state_o != 3'd2 && t < 20) begin
      tick;
      n_hr += int'(hash_rdy);
      t++;
    end
    check_eq("abort_no_hash_rdy", n_hr, 0);
    check_eq("abort_collect", {29'd0, state_o}, 32'd2);

    // fail_count saturation over 260 failures
    do_reset;
    run = 1'b1; ctrl_mode = 1'b0; raw_valid = 1'b1; raw_bit = 1'b0;
    n_ev = 0; prev_fail = 1'b0; t = 0;
    while (n_ev < 260 && t < 6000) begin
      tick;
      t++;
      if (failure && !prev_fail) begin
        n_ev++;
        if (n_ev == 1 || n_ev == 254 || n_ev == 255 || n_ev == 260)
          check_eq("sat_count", {24'd0, fail_count}, (n_ev > 255) ? 32'd255 : n_ev);
      end
      prev_fail = failure;
    end
    check_eq("sat_events", n_ev, 260);
    check_eq("sat_final", {24'd0, fail_count}, 32'd255);

    // asynchronous reset in the middle of COLLECT
    tb_bit = 1'b1;
    t = 0;
    while (state_o != 3'd2 && t < 30) begin
      raw_bit = tb_bit; tb_bit = ~tb_bit;
      tick;
      t++;
    end
    raw_bit = tb_bit; tb_bit = ~tb_bit;
    tick;
    check_eq("pre_rst_wr", {31'd0, buf_wr_en}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check_eq("async_rst_state", {29'd0, state_o}, 32'd0);
    check_eq("async_rst_outs", {24'd0, buf_wr_en, buf_clr, hash_start, hash_rdy,
                                raw_out_valid, failure, raw_out, buf_wr_data}, 32'd0);
    check_eq("async_rst_fail_count", {24'd0, fail_count}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
